led_matrix_scanner: RTL
=======================

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
- REQ-001 SHALL have parameter N_COLS, default 5, number of scanned columns (2..16).
- REQ-002 SHALL have parameter N_ROWS, default 7, row bits per column (1..16).
- REQ-003 SHALL have parameter DWELL_CYCLES, default 50000, drive cycles per column (multiple of 8, >=8).
- REQ-004 SHALL have parameter BLANK_CYCLES, default 16, blanking cycles before each column (>=1).
- REQ-005 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
- REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
- REQ-007 SHALL have port enable, input, 1, scan run request.
- REQ-008 SHALL have port frame_data, input, N_COLS*N_ROWS, new frame; column c occupies bits [c*N_ROWS +: N_ROWS].
- REQ-009 SHALL have port frame_valid, input, 1, frame_data valid.
- REQ-010 SHALL have port frame_ready, output, 1, back buffer free.
- REQ-011 SHALL have port col_en, output, N_COLS, one-hot active-high column drive.
- REQ-012 SHALL have port rows, output, N_ROWS, row values for the driven column.
- REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse at end of last column.

Function
- REQ-014 SHALL implement states IDLE, BLANK, DRIVE.
- REQ-015 IDLE: col_en=0, rows=0, column index=0; enable=1 -> BLANK next cycle.
- REQ-016 BLANK: col_en=0, rows=0 for exactly BLANK_CYCLES cycles, then DRIVE.
- REQ-017 DRIVE: col_en bit[idx]=1 only, rows=front[idx*N_ROWS +: N_ROWS] for exactly DWELL_CYCLES cycles, then BLANK with idx+1.
- REQ-018 Wrap: at end of DRIVE with idx=N_COLS-1, idx SHALL return to 0 and frame_done SHALL pulse high for that one cycle (final DRIVE cycle).
- REQ-019 Handshake: frame_valid&&frame_ready on a rising edge SHALL write frame_data into back buffer and set pending; frame_ready = !pending.
- REQ-020 Swap: on entry to BLANK with idx=0 (incl. from IDLE), if pending, back SHALL copy to front and pending SHALL clear in that same edge; front SHALL never change at any other time.
- REQ-021 Write and swap cannot coincide (frame_ready=0 while pending); frame_valid while frame_ready=0 SHALL be ignored, no data lost from back buffer.
- REQ-022 enable=0 in BLANK or DRIVE SHALL go to IDLE next edge, blanking outputs and resetting idx and counters; pending/buffers retained.
- REQ-023 Outputs SHALL be registered; col_en and rows never both nonzero across a column change (BLANK guarantees >=1 dark cycle).

Reset
- REQ-024 reset=1 SHALL force IDLE, col_en=0, rows=0, frame_done=0, frame_ready=1, pending=0, idx=0, counters=0, front and back buffers=0; reset dominates enable and frame_valid.
- REQ-025 reset mid-DRIVE SHALL blank outputs at the same edge; scan restarts at column 0 after release.

Configuration
- REQ-026 Macro LED_MATRIX_BRIGHTNESS_EN defined: SHALL add input brightness[2:0]; rows SHALL equal column data for the first (brightness+1)*DWELL_CYCLES/8 cycles of DRIVE and 0 for the rest; col_en unaffected; brightness sampled at DRIVE entry.
- REQ-027 Macro undefined: no brightness port; rows driven for all DWELL_CYCLES cycles.

Structure
- REQ-028 Package led_matrix_pkg SHALL hold the state enum (IDLE/BLANK/DRIVE) and default N_COLS, N_ROWS, DWELL_CYCLES, BLANK_CYCLES constants.
- REQ-029 One sub-module led_scan_timer SHALL provide the load/count/terminal-count down-counter shared by BLANK and DRIVE; per-column row selection remains in existing decoder mux logic feeding rows.

Verification (N_COLS=3, N_ROWS=4, DWELL_CYCLES=8, BLANK_CYCLES=1)
- REQ-030 Reset then enable=1, frame 0xABC written -> col_en sequence 000,001(x8),000,010(x8),000,100(x8); rows C,B,A; frame_done pulses on final 100 cycle.
- REQ-031 Write frame mid-column 1 -> frame_ready drops next cycle; displayed data changes only at next column-0 BLANK entry; frame_ready returns 1 there.
- REQ-032 frame_valid held with second frame while pending -> ignored; first frame displayed; second accepted after swap.
- REQ-033 enable=0 during column 2 DRIVE -> next edge col_en=0, rows=0; re-enable restarts at column 0.
- REQ-034 reset=1 during DRIVE with frame_valid=1 -> all outputs per REQ-024 at that edge; frame not captured.
- REQ-035 With LED_MATRIX_BRIGHTNESS_EN, brightness=3 -> rows nonzero 4 of 8 DRIVE cycles; brightness=7 -> 8 of 8.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types and default geometry/timing for the LED matrix column scanner.
package led_matrix_pkg;

    localparam int DEF_N_COLS       = 5;
    localparam int DEF_N_ROWS       = 7;
    localparam int DEF_DWELL_CYCLES = 50000;
    localparam int DEF_BLANK_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_e;

    // Width of a down-counter that must hold both (dwell-1) and (blank-1).
    function automatic int cnt_width(input int dwell, input int blank);
        int m;
        m = (dwell > blank) ? dwell : blank;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Load/count/terminal-count down-counter timing both the BLANK and DRIVE phases.
module led_scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         count_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_next_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for state so all flops update together at the edge.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign tc_o       = (cnt_q == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered LED matrix column scanner with blanking between columns.
// Optional per-frame brightness PWM is enabled by defining LED_MATRIX_BRIGHTNESS_EN.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int N_COLS       = DEF_N_COLS,
    parameter int N_ROWS       = DEF_N_ROWS,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_COLS*N_ROWS-1:0] frame_data,
    input  logic                     frame_valid,
`ifdef LED_MATRIX_BRIGHTNESS_EN
    input  logic [2:0]               brightness,
`endif
    output logic                     frame_ready,
    output logic [N_COLS-1:0]        col_en,
    output logic [N_ROWS-1:0]        rows,
    output logic                     frame_done
);

    localparam int FB_W  = N_COLS * N_ROWS;
    localparam int IDX_W = $clog2(N_COLS);
    localparam int CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_COLS - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FB_W-1:0]   front_q, front_d, back_q, back_d;
    logic              pending_q, pending_d;
    logic [N_COLS-1:0] col_en_q, col_en_d;
    logic [N_ROWS-1:0] rows_q, rows_d;
    logic              done_q, done_d;

    logic              t_clear, t_load, t_count, t_tc, col0_entry;
    logic [CNT_W-1:0]  t_load_val, t_cnt, t_cnt_next;

    led_scan_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (t_clear),
        .load_i     (t_load),
        .load_val_i (t_load_val),
        .count_i    (t_count),
        .cnt_o      (t_cnt),
        .cnt_next_o (t_cnt_next),
        .tc_o       (t_tc)
    );

`ifdef LED_MATRIX_BRIGHTNESS_EN
    localparam int                CW1    = CNT_W + 1;
    localparam logic [CNT_W:0]    STEP_W = CW1'(DWELL_CYCLES / 8);
    logic [2:0]     bright_q, bright_d;
    logic [CNT_W:0] dark_thr;

    assign bright_d = (state_q != DRIVE && state_d == DRIVE) ? brightness : bright_q;
    // Rows are lit while the remaining count is at or above (7-brightness) eighths.
    assign dark_thr = CW1'(3'd7 - bright_d) * STEP_W;

    always_ff @(posedge clk) begin
        if (reset) bright_q <= '0;
        else       bright_q <= bright_d;
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: frame buffers are reset because blank-on-reset content is required behaviour.
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            front_q   <= '0;
            back_q    <= '0;
            pending_q <= 1'b0;
            col_en_q  <= '0;
            rows_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            front_q   <= front_d;
            back_q    <= back_d;
            pending_q <= pending_d;
            col_en_q  <= col_en_d;
            rows_q    <= rows_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        t_clear    = 1'b0;
        t_load     = 1'b0;
        t_load_val = '0;
        t_count    = 1'b0;
        col0_entry = 1'b0;
        unique case (state_q)
            IDLE: if (enable) begin
                state_d    = BLANK;
                t_load     = 1'b1;
                t_load_val = BLANK_LOAD;
                col0_entry = 1'b1;
            end
            BLANK: if (!enable) begin
                state_d = IDLE;
                idx_d   = '0;
                t_clear = 1'b1;
            end else if (t_tc) begin
                state_d    = DRIVE;
                t_load     = 1'b1;
                t_load_val = DWELL_LOAD;
            end else begin
                t_count = 1'b1;
            end
            DRIVE: if (!enable) begin
                state_d = IDLE;
                idx_d   = '0;
                t_clear = 1'b1;
            end else if (t_tc) begin
                state_d    = BLANK;
                t_load     = 1'b1;
                t_load_val = BLANK_LOAD;
                if (idx_q == LAST_IDX) begin
                    idx_d      = '0;
                    col0_entry = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                t_count = 1'b1;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                t_clear = 1'b1;
            end
        endcase
    end

    // Swap and write are exclusive: a swap needs pending, a write needs !pending.
    always_comb begin
        front_d   = front_q;
        back_d    = back_q;
        pending_d = pending_q;
        if (col0_entry && pending_q) begin
            front_d   = back_q;
            pending_d = 1'b0;
        end
        if (frame_valid && !pending_q) begin
            back_d    = frame_data;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        col_en_d = '0;
        rows_d   = '0;
        done_d   = 1'b0;
        if (state_d == DRIVE) begin
            col_en_d[idx_d] = 1'b1;
            rows_d          = front_d[idx_d*N_ROWS +: N_ROWS];
`ifdef LED_MATRIX_BRIGHTNESS_EN
            if ({1'b0, t_cnt_next} < dark_thr) rows_d = '0;
`endif
            done_d = (t_cnt_next == '0) && (idx_d == LAST_IDX);
        end
    end

    assign frame_ready = !pending_q;
    assign col_en      = col_en_q;
    assign rows        = rows_q;
    assign frame_done  = done_q;

endmodule
